// File: rtl/val2_shift_pipe.sv
// Val2 operand generator with ARM shifter carry-out for the EXE stage.
// One (PIPE=1) or two (PIPE=2) register stages behind a valid/ready handshake with flush.
module val2_shift_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PIPE   = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem,
    input  logic              in_imm,
    input  logic              in_reg_shift,
    input  logic [11:0]       in_shift_op,
    input  logic [DATA_W-1:0] in_rm,
    input  logic [7:0]        in_rs,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val2,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);
    typedef enum logic [1:0] {MODE_MEM, MODE_IMM, MODE_SHIFT} mode_e;
    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shtype_e;

    // Returns {carry, val2}. Right shifts by >= DATA_W yield zero, which covers the
    // reg-amount LSL/LSR saturation cases without separate range decoding.
    function automatic logic [DATA_W:0] shift_eval(
        input mode_e             mode,
        input shtype_e           ty,
        input logic [7:0]        amt,
        input logic              by_reg,
        input logic [DATA_W-1:0] opnd,
        input logic              cin
    );
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] t;
        logic              c;
        logic              msb;
        int unsigned       a;
        int unsigned       r;
        a   = 32'(amt);
        r   = a % DATA_W;
        msb = opnd[DATA_W-1];
        v   = opnd;
        c   = cin;
        t   = '0;
        case (mode)
            MODE_MEM: begin
                v = opnd;
            end
            MODE_IMM: begin
                v = (opnd >> a) | (opnd << (DATA_W - a));
                if (a != 0) c = v[DATA_W-1];
            end
            default: begin
                if (a == 0) begin
                    if (!by_reg) begin
                        case (ty)
                            SH_LSL: v = opnd;
                            SH_LSR: begin v = '0;              c = msb;     end
                            SH_ASR: begin v = {DATA_W{msb}};   c = msb;     end
                            default: begin v = {cin, opnd[DATA_W-1:1]}; c = opnd[0]; end
                        endcase
                    end
                end else begin
                    case (ty)
                        SH_LSL: begin
                            v = opnd << a;
                            t = opnd >> (DATA_W - a);
                            c = t[0];
                        end
                        SH_LSR: begin
                            v = opnd >> a;
                            t = opnd >> (a - 1);
                            c = t[0];
                        end
                        SH_ASR: begin
                            if (a >= DATA_W) begin
                                v = {DATA_W{msb}};
                                c = msb;
                            end else begin
                                v = $signed(opnd) >>> a;
                                t = opnd >> (a - 1);
                                c = t[0];
                            end
                        end
                        default: begin
                            if (r == 0) begin
                                v = opnd;
                                c = msb;
                            end else begin
                                v = (opnd >> r) | (opnd << (DATA_W - r));
                                t = opnd >> (r - 1);
                                c = t[0];
                            end
                        end
                    endcase
                end
            end
        endcase
        return {c, v};
    endfunction

    mode_e             dec_mode;
    shtype_e           dec_type;
    logic [7:0]        dec_amt;
    logic              dec_reg;
    logic [DATA_W-1:0] dec_opnd;
    logic              unused_so4;

    assign unused_so4 = in_shift_op[4];

    always_comb begin
        dec_mode = MODE_SHIFT;
        dec_type = shtype_e'(in_shift_op[6:5]);
        dec_amt  = in_reg_shift ? in_rs : {3'b000, in_shift_op[11:7]};
        dec_reg  = in_reg_shift;
        dec_opnd = in_rm;
        if (in_mem) begin
            dec_mode = MODE_MEM;
            dec_reg  = 1'b0;
            dec_amt  = '0;
            dec_opnd = {{(DATA_W-12){in_shift_op[11]}}, in_shift_op};
        end else if (in_imm) begin
            dec_mode = MODE_IMM;
            dec_reg  = 1'b0;
            dec_amt  = {3'b000, in_shift_op[11:8], 1'b0};
            dec_opnd = {{(DATA_W-8){1'b0}}, in_shift_op[7:0]};
        end
    end

    logic              out_valid_q;
    logic [DATA_W-1:0] out_val2_q;
    logic              out_carry_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_can_load;
    logic              out_load;

    logic              feed_valid;
    mode_e             feed_mode;
    shtype_e           feed_type;
    logic [7:0]        feed_amt;
    logic              feed_reg;
    logic [DATA_W-1:0] feed_opnd;
    logic              feed_cin;
    logic [TAG_W-1:0]  feed_tag;
    logic [DATA_W:0]   result_d;

    assign out_can_load = !out_valid_q || out_ready;
    assign out_load     = feed_valid && out_can_load && !flush;

    if (PIPE == 2) begin : g_pipe2
        logic              s1_valid_q;
        mode_e             s1_mode_q;
        shtype_e           s1_type_q;
        logic [7:0]        s1_amt_q;
        logic              s1_reg_q;
        logic [DATA_W-1:0] s1_opnd_q;
        logic              s1_cin_q;
        logic [TAG_W-1:0]  s1_tag_q;

        assign in_ready = !flush && (!s1_valid_q || out_can_load);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_mode_q  <= MODE_MEM;
                s1_type_q  <= SH_LSL;
                s1_amt_q   <= '0;
                s1_reg_q   <= 1'b0;
                s1_opnd_q  <= '0;
                s1_cin_q   <= 1'b0;
                s1_tag_q   <= '0;
            end else if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (in_valid && in_ready) begin
                s1_valid_q <= 1'b1;
                s1_mode_q  <= dec_mode;
                s1_type_q  <= dec_type;
                s1_amt_q   <= dec_amt;
                s1_reg_q   <= dec_reg;
                s1_opnd_q  <= dec_opnd;
                s1_cin_q   <= in_carry;
                s1_tag_q   <= in_tag;
            end else if (out_load) begin
                s1_valid_q <= 1'b0;
            end
        end

        assign feed_valid = s1_valid_q;
        assign feed_mode  = s1_mode_q;
        assign feed_type  = s1_type_q;
        assign feed_amt   = s1_amt_q;
        assign feed_reg   = s1_reg_q;
        assign feed_opnd  = s1_opnd_q;
        assign feed_cin   = s1_cin_q;
        assign feed_tag   = s1_tag_q;
    end else begin : g_pipe1
        assign in_ready   = !flush && out_can_load;
        assign feed_valid = in_valid;
        assign feed_mode  = dec_mode;
        assign feed_type  = dec_type;
        assign feed_amt   = dec_amt;
        assign feed_reg   = dec_reg;
        assign feed_opnd  = dec_opnd;
        assign feed_cin   = in_carry;
        assign feed_tag   = in_tag;
    end

    assign result_d = shift_eval(feed_mode, feed_type, feed_amt, feed_reg, feed_opnd, feed_cin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_val2_q  <= '0;
            out_carry_q <= 1'b0;
            out_tag_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_val2_q  <= result_d[DATA_W-1:0];
            out_carry_q <= result_d[DATA_W];
            out_tag_q   <= feed_tag;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_val2  = out_val2_q;
    assign out_carry = out_carry_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_val2_shift_pipe.sv
// Directed bench for val2_shift_pipe: PIPE=1 and PIPE=2 instances share request fields.
// Each scenario task drives stimulus and compares against hand-computed values inline.
module tb_val2_shift_pipe;
    typedef struct packed {
        logic        mem;
        logic        imm;
        logic        regs;
        logic [11:0] so;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic        cin;
        logic [31:0] ev;
        logic        ec;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        iv1, iv2;
    logic        ir1, ir2;
    logic        in_mem, in_imm, in_reg_shift;
    logic [11:0] in_shift_op;
    logic [31:0] in_rm;
    logic [7:0]  in_rs;
    logic        in_carry;
    logic [3:0]  in_tag;
    logic        ov_1, ov_2;
    logic        ordy1, ordy2;
    logic [31:0] val_1, val_2;
    logic        c_1, c_2;
    logic [3:0]  tag_1, tag_2;

    int n_checks = 0;
    int n_pass   = 0;

    val2_shift_pipe #(.DATA_W(32), .PIPE(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv1), .in_ready(ir1),
        .in_mem(in_mem), .in_imm(in_imm), .in_reg_shift(in_reg_shift),
        .in_shift_op(in_shift_op), .in_rm(in_rm), .in_rs(in_rs),
        .in_carry(in_carry), .in_tag(in_tag),
        .out_valid(ov_1), .out_ready(ordy1),
        .out_val2(val_1), .out_carry(c_1), .out_tag(tag_1)
    );

    val2_shift_pipe #(.DATA_W(32), .PIPE(2), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv2), .in_ready(ir2),
        .in_mem(in_mem), .in_imm(in_imm), .in_reg_shift(in_reg_shift),
        .in_shift_op(in_shift_op), .in_rm(in_rm), .in_rs(in_rs),
        .in_carry(in_carry), .in_tag(in_tag),
        .out_valid(ov_2), .out_ready(ordy2),
        .out_val2(val_2), .out_carry(c_2), .out_tag(tag_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] b2b_so(input int k);
        return 12'(k * 433 + 2000);
    endfunction

    // Issues one request to both DUTs, then scrambles every input so late sampling shows up.
    task automatic run_op(input vec_t v, input logic [3:0] tg,
                          output logic rdy1, output logic rdy2,
                          output logic ov1, output logic ov2a, output logic ov2,
                          output logic [31:0] r1, output logic [31:0] r2,
                          output logic c1, output logic c2,
                          output logic [3:0] t1, output logic [3:0] t2);
        @(negedge clk);
        in_mem = v.mem; in_imm = v.imm; in_reg_shift = v.regs;
        in_shift_op = v.so; in_rm = v.rm; in_rs = v.rs; in_carry = v.cin; in_tag = tg;
        iv1 = 1'b1; iv2 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
        #1;
        rdy1 = ir1; rdy2 = ir2;
        @(posedge clk);
        #1;
        iv1 = 1'b0; iv2 = 1'b0;
        in_mem = ~v.mem; in_imm = ~v.imm; in_reg_shift = ~v.regs;
        in_shift_op = ~v.so; in_rm = ~v.rm; in_rs = ~v.rs; in_carry = ~v.cin; in_tag = ~tg;
        @(negedge clk);
        #1;
        ov1 = ov_1; r1 = val_1; c1 = c_1; t1 = tag_1; ov2a = ov_2;
        @(negedge clk);
        #1;
        ov2 = ov_2; r2 = val_2; c2 = c_2; t2 = tag_2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({ov_1, c_1, tag_1, val_1} !== 38'd0)
            $display("FAIL reset_dut1 {valid,c,tag,val2}: got %h expected 0", {ov_1, c_1, tag_1, val_1});
        else n_pass++;
        n_checks++;
        if ({ov_2, c_2, tag_2, val_2} !== 38'd0)
            $display("FAIL reset_dut2 {valid,c,tag,val2}: got %h expected 0", {ov_2, c_2, tag_2, val_2});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({ir1, ir2} !== 2'b11)
            $display("FAIL reset_in_ready {dut1,dut2}: got %b expected 11", {ir1, ir2});
        else n_pass++;
    endtask

    task automatic test_modes();
        vec_t        tbl [9];
        logic        rdy1, rdy2, ov1, ov2a, ov2, c1, c2;
        logic [31:0] r1, r2;
        logic [3:0]  t1, t2, tg;
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 12'hFFC, 32'h0000_0000, 8'h00, 1'b1, 32'hFFFF_FFFC, 1'b1},
            '{1'b1, 1'b0, 1'b0, 12'hFFC, 32'h0000_0000, 8'h00, 1'b0, 32'hFFFF_FFFC, 1'b0},
            '{1'b1, 1'b0, 1'b0, 12'h7FF, 32'hDEAD_BEEF, 8'h00, 1'b1, 32'h0000_07FF, 1'b1},
            '{1'b1, 1'b1, 1'b0, 12'h4FF, 32'h0000_0000, 8'h00, 1'b0, 32'h0000_04FF, 1'b0},
            '{1'b0, 1'b1, 1'b0, 12'h4FF, 32'h0000_0000, 8'h00, 1'b0, 32'hFF00_0000, 1'b1},
            '{1'b0, 1'b1, 1'b0, 12'h0FF, 32'h0000_0000, 8'h00, 1'b1, 32'h0000_00FF, 1'b1},
            '{1'b0, 1'b1, 1'b0, 12'h0FF, 32'h0000_0000, 8'h00, 1'b0, 32'h0000_00FF, 1'b0},
            '{1'b0, 1'b1, 1'b1, 12'h101, 32'hFFFF_FFFF, 8'h10, 1'b1, 32'h4000_0000, 1'b0},
            '{1'b0, 1'b1, 1'b0, 12'h480, 32'h0000_0000, 8'h00, 1'b0, 32'h8000_0000, 1'b1}
        };
        for (int i = 0; i < 9; i++) begin
            tg = 4'(i + 1);
            run_op(tbl[i], tg, rdy1, rdy2, ov1, ov2a, ov2, r1, r2, c1, c2, t1, t2);
            n_checks++;
            if ({rdy1, rdy2} !== 2'b11)
                $display("FAIL mode[%0d] in_ready: got %b expected 11", i, {rdy1, rdy2});
            else n_pass++;
            n_checks++;
            if ({ov1, ov2a, ov2} !== 3'b101)
                $display("FAIL mode[%0d] latency {dut1@1,dut2@1,dut2@2}: got %b expected 101", i, {ov1, ov2a, ov2});
            else n_pass++;
            n_checks++;
            if ({c1, t1, r1} !== {tbl[i].ec, tg, tbl[i].ev})
                $display("FAIL mode[%0d] dut1 {c,tag,val2}: got %h expected %h", i, {c1, t1, r1}, {tbl[i].ec, tg, tbl[i].ev});
            else n_pass++;
            n_checks++;
            if ({c2, t2, r2} !== {tbl[i].ec, tg, tbl[i].ev})
                $display("FAIL mode[%0d] dut2 {c,tag,val2}: got %h expected %h", i, {c2, t2, r2}, {tbl[i].ec, tg, tbl[i].ev});
            else n_pass++;
        end
    endtask

    task automatic test_shifts();
        vec_t        tbl [22];
        logic        rdy1, rdy2, ov1, ov2a, ov2, c1, c2;
        logic [31:0] r1, r2;
        logic [3:0]  t1, t2, tg;
        tbl = '{
            '{1'b0, 1'b0, 1'b0, 12'h060, 32'h0000_0003, 8'd0,   1'b1, 32'h8000_0001, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h060, 32'h0000_0002, 8'd0,   1'b0, 32'h0000_0001, 1'b0},
            '{1'b0, 1'b0, 1'b0, 12'h000, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h200, 32'hF000_0001, 8'd0,   1'b0, 32'h0000_0010, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h020, 32'h8000_0000, 8'd0,   1'b0, 32'h0000_0000, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h0A0, 32'h0000_0003, 8'd0,   1'b0, 32'h0000_0001, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h040, 32'h8000_0000, 8'd0,   1'b0, 32'hFFFF_FFFF, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h240, 32'h8000_0008, 8'd0,   1'b0, 32'hF800_0000, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'h460, 32'h0000_00A5, 8'd0,   1'b0, 32'hA500_0000, 1'b1},
            '{1'b0, 1'b0, 1'b0, 12'hF80, 32'h0000_0003, 8'd0,   1'b0, 32'h8000_0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0001, 8'd33,  1'b1, 32'h0000_0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 12'h060, 32'h8000_0000, 8'd64,  1'b0, 32'h8000_0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h020, 32'h0000_0005, 8'd0,   1'b1, 32'h0000_0005, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h060, 32'h0000_0005, 8'd0,   1'b0, 32'h0000_0005, 1'b0},
            '{1'b0, 1'b0, 1'b1, 12'h020, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h040, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h040, 32'h4000_0000, 8'd200, 1'b1, 32'h0000_0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 12'h060, 32'h0000_000F, 8'd36,  1'b0, 32'hF000_0000, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h000, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1},
            '{1'b0, 1'b0, 1'b1, 12'h020, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 12'hFA0, 32'h0000_0010, 8'd4,   1'b1, 32'h0000_0001, 1'b0}
        };
        for (int i = 0; i < 22; i++) begin
            tg = 4'(i + 5);
            run_op(tbl[i], tg, rdy1, rdy2, ov1, ov2a, ov2, r1, r2, c1, c2, t1, t2);
            n_checks++;
            if ({ov1, ov2a, ov2} !== 3'b101)
                $display("FAIL shift[%0d] latency {dut1@1,dut2@1,dut2@2}: got %b expected 101", i, {ov1, ov2a, ov2});
            else n_pass++;
            n_checks++;
            if ({c1, t1, r1} !== {tbl[i].ec, tg, tbl[i].ev})
                $display("FAIL shift[%0d] dut1 {c,tag,val2}: got %h expected %h", i, {c1, t1, r1}, {tbl[i].ec, tg, tbl[i].ev});
            else n_pass++;
            n_checks++;
            if ({c2, t2, r2} !== {tbl[i].ec, tg, tbl[i].ev})
                $display("FAIL shift[%0d] dut2 {c,tag,val2}: got %h expected %h", i, {c2, t2, r2}, {tbl[i].ec, tg, tbl[i].ev});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int          sent, got;
        logic        stalled;
        logic [36:0] held, obs, expv;
        logic [11:0] exp_so;
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        in_mem = 1'b1; in_imm = 1'b0; in_reg_shift = 1'b0; in_rm = '0; in_rs = '0;
        iv1 = 1'b0; ordy1 = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            ordy2 = (cyc % 2 == 0);
            iv2 = (sent < 8);
            in_shift_op = b2b_so(sent);
            in_carry = sent[0];
            in_tag = 4'(sent + 3);
            #1;
            obs = {c_2, tag_2, val_2};
            if (stalled) begin
                n_checks++;
                if (!(ov_2 === 1'b1 && obs === held))
                    $display("FAIL b2b_stall_hold item %0d: got valid=%b %h expected valid=1 %h", got, ov_2, obs, held);
                else n_pass++;
            end
            if (ov_2 === 1'b1 && ordy2) begin
                exp_so = b2b_so(got);
                expv = {got[0], 4'(got + 3), {{20{exp_so[11]}}, exp_so}};
                n_checks++;
                if (obs !== expv)
                    $display("FAIL b2b_item[%0d] {c,tag,val2}: got %h expected %h", got, obs, expv);
                else n_pass++;
                got++;
            end
            stalled = (ov_2 === 1'b1) && !ordy2;
            held = obs;
            if (iv2 && ir2 === 1'b1) sent++;
        end
        iv2 = 1'b0;
        ordy2 = 1'b1;
        n_checks++;
        if (got != 8 || sent != 8)
            $display("FAIL b2b_count {sent,received}: got %0d,%0d expected 8,8", sent, got);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (ov_2 !== 1'b0)
            $display("FAIL b2b_no_duplicate out_valid: got %b expected 0", ov_2);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        in_mem = 1'b1; in_imm = 1'b0; in_reg_shift = 1'b0;
        ordy1 = 1'b1; ordy2 = 1'b0; iv1 = 1'b0; iv2 = 1'b1;
        in_shift_op = 12'h111; in_tag = 4'h1; in_carry = 1'b1;
        @(negedge clk);
        in_shift_op = 12'h222; in_tag = 4'h2;
        @(negedge clk);
        in_shift_op = 12'h333; in_tag = 4'h3;
        flush = 1'b1;
        #1;
        n_checks++;
        if (ov_2 !== 1'b1)
            $display("FAIL flush_precondition out_valid: got %b expected 1", ov_2);
        else n_pass++;
        n_checks++;
        if ({ir1, ir2} !== 2'b00)
            $display("FAIL flush_in_ready {dut1,dut2}: got %b expected 00", {ir1, ir2});
        else n_pass++;
        @(negedge clk);
        flush = 1'b0; iv2 = 1'b0; ordy2 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (ov_2 !== 1'b0 || ov_1 !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL flush_nothing_emitted: got output seen=%b expected 0", seen);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic seen;
        @(negedge clk);
        in_mem = 1'b1; in_imm = 1'b0; in_reg_shift = 1'b0;
        ordy1 = 1'b0; ordy2 = 1'b0; iv1 = 1'b1; iv2 = 1'b1;
        in_shift_op = 12'h555; in_tag = 4'h5; in_carry = 1'b1;
        @(negedge clk);
        in_shift_op = 12'h666; in_tag = 4'h6;
        @(negedge clk);
        iv1 = 1'b0; iv2 = 1'b0;
        #1;
        n_checks++;
        if ({ov_1, ov_2} !== 2'b11)
            $display("FAIL midreset_precondition {dut1,dut2} out_valid: got %b expected 11", {ov_1, ov_2});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov_1, c_1, tag_1, val_1} !== 38'd0)
            $display("FAIL midreset_dut1 {valid,c,tag,val2}: got %h expected 0", {ov_1, c_1, tag_1, val_1});
        else n_pass++;
        n_checks++;
        if ({ov_2, c_2, tag_2, val_2} !== 38'd0)
            $display("FAIL midreset_dut2 {valid,c,tag,val2}: got %h expected 0", {ov_2, c_2, tag_2, val_2});
        else n_pass++;
        #2;
        rst_n = 1'b1;
        ordy1 = 1'b1; ordy2 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (ov_1 !== 1'b0 || ov_2 !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL midreset_entries_dropped: got output seen=%b expected 0", seen);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        iv1 = 1'b0; iv2 = 1'b0; ordy1 = 1'b1; ordy2 = 1'b1;
        in_mem = 1'b0; in_imm = 1'b0; in_reg_shift = 1'b0;
        in_shift_op = '0; in_rm = '0; in_rs = '0; in_carry = 1'b0; in_tag = '0;
        test_reset();
        test_modes();
        test_shifts();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
